// File: rtl/event_flasher.sv
// event_flasher: stretches single-cycle event pulses into fixed-length flashes, queuing events that arrive mid-flash
module event_flasher #(
  parameter int ON_CYCLES = 25_000_000,
  parameter int GAP_CYCLES = 12_500_000,
  parameter int QW = 3
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          pi,
  output logic          lo,
  output logic          busy,
  output logic [QW-1:0] pend,
  output logic          ovf
);
  localparam int MX = ON_CYCLES > GAP_CYCLES ? ON_CYCLES : GAP_CYCLES;
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  localparam logic [CW-1:0] ON_LD = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);
  localparam logic [QW-1:0] PMAX = '1;
  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [QW-1:0] pend_n;
  logic act, done, has, inc, deq, drop;
  // next state, counter reload and queue bookkeeping; an IDLE event is flashed directly, others are queued
  always_comb begin
    act = state == ON || state == GAP;
    done = cnt == '0;
    has = pend != '0;
    inc = pi && (act || has);
    deq = has && (!act || (state == GAP && done));
    drop = inc && !deq && pend == PMAX;
    state_n = !act ? ((pi || has) ? ON : IDLE) : !done ? state : state == ON ? GAP : has ? ON : IDLE;
    cnt_n = (state_n == ON && state != ON) ? ON_LD : (state_n == GAP && state == ON) ? GAP_LD : done ? '0 : cnt - CW'(1);
    pend_n = drop ? pend : pend + QW'(inc) - QW'(deq);
  end
  // state register; lo and busy are registered from the next state so they rise together
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt <= '0;
      pend <= '0;
      ovf <= 1'b0;
      lo <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pend <= pend_n;
      ovf <= ovf | drop;
      lo <= state_n == ON;
      busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_event_flasher.sv
// tb_event_flasher: directed and random pulse streams checked against a flash-schedule model
module tb_event_flasher;
  localparam int ON = 4, GAP = 2, QW = 2, MAX = (1 << QW) - 1;
  logic Clk = 0, Rst = 1, pi = 0, lo, busy, ovf, prev_lo = 0, ovf_m = 0;
  logic [QW-1:0] pend;
  int cyc = 0, cmps = 0, errs = 0, flashes = 0;
  int ss[$];
  event_flasher #(.ON_CYCLES(ON), .GAP_CYCLES(GAP), .QW(QW)) dut (
    .Clk(Clk), .Rst(Rst), .pi(pi), .lo(lo), .busy(busy), .pend(pend), .ovf(ovf)
  );
  always #5 Clk = ~Clk;
  // schedule an event seen in cycle t: it flashes after the previous flash's gap, or is dropped when the queue is full
  task automatic model_event(input int t);
    int p = 0, g, st;
    bit deq = 0;
    foreach (ss[i]) begin
      if (ss[i] > t) p++;
      if (ss[i] == t + 1) deq = 1;
    end
    if (p == MAX && !deq) begin
      ovf_m = 1;
      return;
    end
    if (ss.size() == 0) st = t + 1;
    else begin
      g = ss[$] + ON + GAP - 1;
      st = t < g ? g + 1 : t == g ? t + 2 : t + 1;
    end
    ss.push_back(st);
  endtask
  task automatic check();
    logic e_lo = 0, e_busy = 0;
    int e_pend = 0;
    foreach (ss[i]) begin
      if (ss[i] <= cyc && cyc < ss[i] + ON) e_lo = 1;
      if (ss[i] <= cyc && cyc < ss[i] + ON + GAP) e_busy = 1;
      if (ss[i] > cyc) e_pend++;
    end
    cmps++;
    assert (lo === e_lo) else begin errs++; $error("FAIL lo cyc=%0d got=%b exp=%b", cyc, lo, e_lo); end
    cmps++;
    assert (busy === e_busy) else begin errs++; $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
    cmps++;
    assert (pend === QW'(e_pend)) else begin errs++; $error("FAIL pend cyc=%0d got=%0d exp=%0d", cyc, pend, e_pend); end
    cmps++;
    assert (ovf === ovf_m) else begin errs++; $error("FAIL ovf cyc=%0d got=%b exp=%b", cyc, ovf, ovf_m); end
  endtask
  task automatic step(input logic p, input logic r);
    pi = p;
    Rst = r;
    if (r) begin
      ss.delete();
      ovf_m = 0;
    end else if (p) model_event(cyc);
    @(posedge Clk);
    #1;
    cyc++;
    check();
    if (lo && !prev_lo) flashes++;
    prev_lo = lo;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0);
  endtask
  initial begin
    step(1, 1);
    step(0, 1);
    idle(7);
    step(1, 0);
    idle(12);
    step(1, 0); step(0, 0); step(1, 0); step(1, 0);
    idle(25);
    flashes = 0;
    repeat (6) step(1, 0);
    idle(40);
    cmps++;
    assert (flashes === 4) else begin errs++; $error("FAIL ovf_flashes got=%0d exp=4", flashes); end
    step(0, 1);
    step(1, 0);
    idle(5);
    step(1, 0);
    idle(15);
    step(1, 0); step(0, 0); step(0, 1); step(0, 0); step(0, 0); step(1, 0);
    idle(10);
    flashes = 0;
    repeat (3) step(1, 0);
    idle(30);
    cmps++;
    assert (flashes === 3) else begin errs++; $error("FAIL held_flashes got=%0d exp=3", flashes); end
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, (k / 500) % 3 + 1) == 0, $urandom_range(0, 199) == 0);
    idle(30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule

// File: doc/event_flasher.md
# event_flasher

Output-side counterpart to the button synchronizer. It converts single-cycle event pulses from game logic (score, paddle hit, serve) into human-visible LED/buzzer flashes of fixed length. Events that arrive during a flash are queued and replayed as separate flashes with a dark gap between them. The block sits between game-state logic and the board's output pins, in the same clock domain as the synchronized button pulses.

## Interface
- ON_CYCLES, 25_000_000: clock cycles the output stays high per flash; must be ≥1.
- GAP_CYCLES, 12_500_000: clock cycles the output stays low between queued flashes; must be ≥1.
- QW, 3: width of the pending-event counter; the queue holds up to 2^QW−1 events.
- Clk  in  1  system clock; all logic is on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- pi  in  1  event pulse, nominally one cycle wide. Every cycle it is sampled high counts as one event.
- lo  out  1  flash output, registered.
- busy  out  1  high whenever the state is not IDLE.
- pend  out  QW  number of queued events not yet flashed.
- ovf  out  1  sticky; set when an event is dropped because the queue is full.

## Operation
- States: IDLE, ON, GAP. One down-counter cnt, sized to hold max(ON_CYCLES, GAP_CYCLES).
- Reset (Rst high at an edge): state=IDLE, lo=0, busy=0, pend=0, ovf=0, cnt=0. Rst takes priority over everything, including mid-flash and mid-gap. The flash aborts immediately and any in-progress flash is not resumed.
- IDLE, pi=1: go to ON, load cnt=ON_CYCLES−1, lo=1. This event does not increment pend.
- ON: lo=1 and cnt decrements each cycle. When cnt=0, go to GAP, load cnt=GAP_CYCLES−1, lo=0.
- GAP: lo=0 and cnt decrements each cycle. When cnt=0:
  - if pend>0: decrement pend, go to ON, load cnt=ON_CYCLES−1, lo=1;
  - otherwise go to IDLE.
- pi=1 while in ON or GAP: pend increments. If pend is already 2^QW−1, pend holds and ovf is set to 1.
- Simultaneous pi=1 and a dequeue at the end of GAP: pend is unchanged (+1−1). ovf is not set, even if pend was full.
- ovf is cleared only by Rst.
- busy is a registered copy of (next state ≠ IDLE), so busy and lo rise on the same edge.

## Timing
- Latency: pi high in cycle N while IDLE gives lo=1 from edge N+1.
- Flash length: lo is high for exactly ON_CYCLES cycles.
- Gap length: lo is low for exactly GAP_CYCLES cycles between back-to-back flashes.
- A pi arriving in the final GAP cycle with pend=0 is queued. In that cycle the state moves to IDLE with pend=1. The next cycle then sees IDLE with pend≠0, so IDLE also dequeues:
  - IDLE with pend>0 and pi=0: decrement pend, go to ON;
  - IDLE with pend>0 and pi=1: pend is unchanged, go to ON.
- A flash or gap never shortens or extends because of pi activity.
- pi held high for k cycles counts as k events. Callers must pulse it for one cycle per event.
- Total time for n events with no overflow: n·ON_CYCLES + (n−1)·GAP_CYCLES cycles of busy, plus one trailing GAP.

## Test plan
All scenarios use ON_CYCLES=4, GAP_CYCLES=2, QW=2.
- Single event: after reset, pi=1 for one cycle at cycle 10 -> lo=1 during cycles 11–14, lo=0 from 15, busy=0 from cycle 17, pend stays 0.
- Burst: pi pulses at cycles 10, 12 and 13 -> flashes in cycles 11–14, 17–20 and 23–26; pend peaks at 2 and reaches 0 by cycle 23; ovf=0.
- Overflow: pi at cycle 10 followed by 5 pulses during the first flash -> pend saturates at 3, ovf=1; exactly 4 flashes occur; ovf stays 1 afterwards.
- Last-gap event: pi at cycle 10 and again at cycle 16 (the final GAP cycle) -> second flash occupies cycles 18–21 with no pulse lost.
- Reset mid-flash: pi at cycle 10, Rst=1 at cycle 12 -> lo=0, busy=0, pend=0 from cycle 13; a new pi at cycle 15 gives a full 4-cycle flash in cycles 16–19.
- Held input: pi high for cycles 10–12 -> 3 flashes (pend reaches 2); confirms per-cycle event counting.
